// File: rtl/cnt_period_seq.sv
// cnt_period_seq: command sequencer for a 4-bit loadable binary counter.
// A command (preset, repeat count) is accepted over a valid/ready handshake.
// The block then drives the counter's ld/cnt/data inputs and watches its
// carry-out to build periods of programmable length. It emits one tick per
// completed period and a done pulse after the last period of a finite command.
// A repeat count of zero runs periods continuously until stop_i or reset.

module cnt_period_seq #(
    parameter int CNT_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CNT_W-1:0] preset_i,
    input  logic [REP_W-1:0] reps_i,
    input  logic             pause_i,
    input  logic             stop_i,
    input  logic             carry_i,
    output logic             ld_o,
    output logic             cnt_o,
    output logic [CNT_W-1:0] data_o,
    output logic             busy_o,
    output logic             per_tick_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_preset;
    logic [CNT_W-1:0]   w_preset_nxt;
    logic [REP_W-1:0]   r_rem;
    logic [REP_W-1:0]   w_rem_nxt;
    logic               r_tick;
    logic               w_tick_nxt;
    logic               w_accept;

    // A command is taken only while idle and never while reset is held.
    assign cmd_ready_o = (r_state == S_IDLE) && !rst_i;
    assign w_accept    = cmd_valid_i && cmd_ready_o;

    // Counter control and status are decoded straight from the state so the
    // counter sees ld/cnt in the same cycle the sequencer is in LOAD/COUNT.
    assign ld_o       = (r_state == S_LOAD);
    assign data_o     = r_preset;
    assign cnt_o      = (r_state == S_COUNT) && !pause_i && !stop_i;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign per_tick_o = r_tick;

    // State register, latched command fields and the registered period tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_preset <= {CNT_W{1'b0}};
            r_rem    <= REP_ZERO;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_preset <= w_preset_nxt;
            r_rem    <= w_rem_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    // Next-state logic: command accept, period reload, repeat bookkeeping.
    always_comb begin
        w_state_nxt  = r_state;
        w_preset_nxt = r_preset;
        w_rem_nxt    = r_rem;
        w_tick_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_preset_nxt = preset_i;
                    w_rem_nxt    = reps_i;
                    w_state_nxt  = S_LOAD;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_LOAD: begin
                if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                // Abort wins over a carry arriving in the same cycle.
                if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else if (carry_i) begin
                    w_tick_nxt = 1'b1;
                    if (r_rem == REP_ONE) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // Zero means continuous: leave it at zero forever.
                        if (r_rem != REP_ZERO) begin
                            w_rem_nxt = r_rem - REP_ONE;
                        end else begin
                            w_rem_nxt = r_rem;
                        end
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cnt_period_seq.sv
// Self-checking bench for cnt_period_seq. A behavioural 4-bit loadable
// counter closes the loop so carry_i comes from real counting. Cycle 0 is
// the cycle in which a command is accepted; cycle 1 is the first LOAD cycle.

module tb_cnt_period_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] preset;
    logic [3:0] reps;
    logic       pause;
    logic       stop;
    logic       carry;
    logic       carry_inj;
    logic       ld;
    logic       cnt;
    logic [3:0] data;
    logic       busy;
    logic       tick;
    logic       done;
    logic [3:0] m_ctr;

    int n_checks;
    int n_err;

    cnt_period_seq #(.CNT_W(4), .REP_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .preset_i    (preset),
        .reps_i      (reps),
        .pause_i     (pause),
        .stop_i      (stop),
        .carry_i     (carry),
        .ld_o        (ld),
        .cnt_o       (cnt),
        .data_o      (data),
        .busy_o      (busy),
        .per_tick_o  (tick),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit counter model with parallel load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctr <= 4'd0;
        end else if (ld) begin
            m_ctr <= data;
        end else if (cnt) begin
            m_ctr <= m_ctr + 4'd1;
        end else begin
            m_ctr <= m_ctr;
        end
    end

    assign carry = (cnt && !ld && (m_ctr == 4'hF)) || carry_inj;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] preset;
        logic [3:0] reps;
        int         pause_at;
        int         pause_len;
        int         exp_done;
        int         exp_ticks;
        int         exp_first_tick;
        int         exp_ld;
        int         exp_cnt;
        int         exp_busy;
    } vec_t;

    vec_t tbl[6];

    // Offer a command at posedge+1; returns after the accepting edge (+1).
    task automatic issue(input logic [3:0] p, input logic [3:0] r);
        cmd_valid = 1'b1;
        preset    = p;
        reps      = r;
        @(negedge clk);
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_row(input int idx);
        int ld_n, cnt_n, busy_n, tick_n, first_t, last_t, done_n, done_c, bad_data, bad_pause;
        ld_n = 0; cnt_n = 0; busy_n = 0; tick_n = 0; first_t = 0; last_t = 0;
        done_n = 0; done_c = 0; bad_data = 0; bad_pause = 0;
        issue(tbl[idx].preset, tbl[idx].reps);
        for (int c = 1; c <= 60; c++) begin
            pause = (c >= tbl[idx].pause_at) && (c < tbl[idx].pause_at + tbl[idx].pause_len);
            @(negedge clk);
            if (ld) begin
                ld_n++;
                if (data !== tbl[idx].preset) bad_data++;
            end
            if (cnt) cnt_n++;
            if (busy) busy_n++;
            if (tick) begin
                tick_n++;
                if (first_t == 0) first_t = c;
                last_t = c;
            end
            if (done) begin
                done_n++;
                done_c = c;
            end
            if (pause && cnt) bad_pause++;
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
        chk($sformatf("row%0d_done_cycle", idx), done_c, tbl[idx].exp_done);
        chk($sformatf("row%0d_done_count", idx), done_n, 1);
        chk($sformatf("row%0d_ticks", idx), tick_n, tbl[idx].exp_ticks);
        chk($sformatf("row%0d_first_tick", idx), first_t, tbl[idx].exp_first_tick);
        chk($sformatf("row%0d_last_tick", idx), last_t, tbl[idx].exp_done);
        chk($sformatf("row%0d_ld_cycles", idx), ld_n, tbl[idx].exp_ld);
        chk($sformatf("row%0d_cnt_cycles", idx), cnt_n, tbl[idx].exp_cnt);
        chk($sformatf("row%0d_busy_cycles", idx), busy_n, tbl[idx].exp_busy);
        chk($sformatf("row%0d_ld_data_bad", idx), bad_data, 0);
        chk($sformatf("row%0d_cnt_in_pause", idx), bad_pause, 0);
    endtask

    initial begin
        int tick_n, tick_bad, done_n, done_c, ready_bad;
        logic [3:0] held;
        n_checks  = 0;
        n_err     = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        preset    = 4'd0;
        reps      = 4'd0;
        pause     = 1'b0;
        stop      = 1'b0;
        carry_inj = 1'b0;

        //              preset reps pa pl done ticks first ld cnt busy
        tbl[0] = '{4'd12, 4'd2, 0, 0, 11, 2,  6, 2,  8, 11};
        tbl[1] = '{4'd15, 4'd1, 0, 0,  3, 1,  3, 1,  1,  3};
        tbl[2] = '{4'd12, 4'd1, 3, 3,  9, 1,  9, 1,  4,  9};
        tbl[3] = '{4'd0,  4'd3, 0, 0, 52, 3, 18, 3, 48, 52};
        tbl[4] = '{4'd14, 4'd1, 0, 0,  4, 1,  4, 1,  2,  4};
        tbl[5] = '{4'd15, 4'd3, 0, 0,  7, 3,  3, 3,  3,  7};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ld", ld, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_data", data, 0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // Table-driven finite commands
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            run_row(i);
        end

        // Pause holds the counter value
        @(posedge clk);
        #1;
        issue(4'd12, 4'd1);
        repeat (2) begin @(posedge clk); #1; end
        pause = 1'b1;
        @(negedge clk);
        held = m_ctr;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pause_holds_counter", m_ctr, held);
        pause = 1'b0;
        repeat (10) begin @(posedge clk); #1; end

        // Continuous command: tick every 17 cycles, then stop in COUNT
        tick_n = 0; tick_bad = 0; done_n = 0;
        issue(4'd0, 4'd0);
        for (int c = 1; c <= 54; c++) begin
            @(negedge clk);
            if (tick) begin
                tick_n++;
                if (((c - 1) % 17) != 0) tick_bad++;
            end
            if (done) done_n++;
            @(posedge clk);
            #1;
        end
        chk("cont_ticks", tick_n, 3);
        chk("cont_tick_spacing", tick_bad, 0);
        chk("cont_no_done", done_n, 0);
        stop = 1'b1;
        @(negedge clk);
        chk("stop_cnt_same_cycle", cnt, 0);
        chk("stop_busy_same_cycle", busy, 1);
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        chk("stop_busy_next", busy, 0);
        chk("stop_ready_next", cmd_ready, 1);
        chk("stop_no_tick", tick, 0);
        chk("stop_no_done", done, 0);

        // Asynchronous reset in the middle of COUNT
        @(posedge clk);
        #1;
        issue(4'd0, 4'd1);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("arst_ld", ld, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 0);
        chk("arst_data", data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("arst_ready_held", cmd_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready_release", cmd_ready, 1);
        chk("arst_no_tick", tick, 0);
        chk("arst_no_done", done, 0);

        // Command held valid during a busy command
        @(posedge clk);
        #1;
        issue(4'd12, 4'd1);
        repeat (2) begin @(posedge clk); #1; end
        cmd_valid = 1'b1;
        preset    = 4'd5;
        reps      = 4'd1;
        ready_bad = 0;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            if (cmd_ready) ready_bad++;
            @(posedge clk);
            #1;
        end
        chk("held_no_ready_busy", ready_bad, 0);
        @(negedge clk);
        chk("held_ready_idle", cmd_ready, 1);
        chk("held_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("held_ld", ld, 1);
        chk("held_data", data, 5);
        done_n = 0; done_c = 0;
        for (int c = 8; c <= 25; c++) begin
            if (c > 8) @(negedge clk);
            if (done) begin
                done_n++;
                done_c = c;
            end
            @(posedge clk);
            #1;
        end
        chk("held_done_count", done_n, 1);
        chk("held_done_cycle", done_c, 20);

        // Carry outside COUNT is ignored
        carry_inj = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("idle_carry_no_tick", tick, 0);
        chk("idle_carry_no_busy", busy, 0);
        @(posedge clk);
        #1;
        carry_inj = 1'b0;
        issue(4'd12, 4'd1);
        carry_inj = 1'b1;
        @(negedge clk);
        chk("load_with_carry_ld", ld, 1);
        @(posedge clk);
        #1;
        carry_inj = 1'b0;
        @(negedge clk);
        chk("load_carry_no_tick", tick, 0);
        chk("load_carry_count", cnt, 1);
        done_c = 0;
        for (int c = 2; c <= 10; c++) begin
            if (c > 2) @(negedge clk);
            if (done) done_c = c;
            @(posedge clk);
            #1;
        end
        chk("load_carry_done_cycle", done_c, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=expired expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
